btb_update_ctrl: RTL and testbench

Branch-resolution side of the BTB protocol. It records each BTB prediction made at fetch in an in-order prediction queue. When the instruction reaches EX, it compares that prediction against the actual outcome. It then drives the BTB update port (`update`, `updatePC`, `updateTarget`, `mispredicted`) and raises a fetch redirect on mispredict. It sits between the IF-stage BTB lookup and the EX-stage branch unit, closing the predict/update loop.

---
 rtl/btb_pkg.sv | 28 ++
 rtl/btb_pred_fifo.sv | 56 +++++
 rtl/btb_update_ctrl.sv | 131 +++++++++++++
 tb/tb_btb_update_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared BTB types and constants: prediction-queue entry, instruction size,
// BTB address split, and the next-PC helper used by the update controller.
package btb_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    // BTB address split: tag | index | byte offset
    localparam int unsigned BTB_TAG_W = 27;
    localparam int unsigned BTB_IDX_W = 3;
    localparam int unsigned BTB_OFF_W = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] target;
        logic        taken;
    } pred_entry_t;

    // Sequential fall-through wraps modulo 2^32.
    function automatic logic [31:0] next_pc(
        input logic [31:0] pc,
        input logic        jump,
        input logic [31:0] tgt
    );
        return jump ? tgt : pc + 32'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/btb_pred_fifo.sv
// In-order prediction FIFO. Ports: push_i/wdata_i, pop_i/rdata_o (head),
// flush_i (wins over push), full_o, empty_o, count_o (occupancy).
module btb_pred_fifo
    import btb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  pred_entry_t       wdata_i,
    input  logic              pop_i,
    input  logic              flush_i,
    output pred_entry_t       rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    pred_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pop_ok, push_ok;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;
    assign rdata_o = mem[rptr_q];

    // An empty pop is ignored; a full push only lands if a pop frees a slot.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB resolution: queues fetch predictions, checks them at EX, drives the
// BTB update port and a fetch redirect on mispredict; queue flushes then.
// Ports: if_* push side, ex_* resolve side, update*/mispredicted to the BTB,
// redirect_* to fetch, q_full/q_empty status. Optional BTB_UPDATE_STATS_EN
// adds saturating stat_branches/stat_mispredicts counters.
module btb_update_ctrl
    import btb_pkg::*;
#(
    parameter int unsigned QDEPTH = 4
`ifdef BTB_UPDATE_STATS_EN
   ,parameter int unsigned STAT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_fire,
    input  logic [31:0] if_pc,
    input  logic        if_hit,
    input  logic [31:0] if_target,
    input  logic        if_taken,
    input  logic        ex_retire,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        update,
    output logic [31:0] updatePC,
    output logic [31:0] updateTarget,
    output logic        mispredicted,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        q_full,
    output logic        q_empty
`ifdef BTB_UPDATE_STATS_EN
   ,output logic [STAT_W-1:0] stat_branches
   ,output logic [STAT_W-1:0] stat_mispredicts
`endif
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

    pred_entry_t      wr_entry, head;
    logic [CNT_W-1:0] occ;
    logic             pop_v, mis, flush;
    logic [31:0]      pred_npc, act_npc;

    logic        upd_q, upd_d, mis_q, mis_d, rv_q, rv_d;
    logic [31:0] upc_q, upc_d, utgt_q, utgt_d, rpc_q, rpc_d;

    assign wr_entry = '{pc: if_pc, hit: if_hit,
                        target: if_target, taken: if_taken};

    btb_pred_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (if_fire),
        .wdata_i (wr_entry),
        .pop_i   (ex_retire),
        .flush_i (flush),
        .rdata_o (head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (occ)
    );

    // Non-branches still compare: a taken hit on them is an alias mispredict.
    always_comb begin
        pop_v    = ex_retire && (occ != '0);
        pred_npc = next_pc(head.pc, head.hit && head.taken, head.target);
        act_npc  = next_pc(head.pc, ex_is_branch && ex_taken, ex_target);
        mis      = (pred_npc != act_npc);
        flush    = pop_v && mis;
    end

    always_comb begin
        upd_d  = pop_v && ex_is_branch;
        upc_d  = upc_q;
        utgt_d = utgt_q;
        mis_d  = mis_q;
        if (upd_d) begin
            upc_d  = head.pc;
            utgt_d = ex_target;
            mis_d  = mis;
        end
        rv_d  = flush;
        rpc_d = rpc_q;
        if (rv_d) rpc_d = act_npc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upd_q  <= 1'b0;
            upc_q  <= '0;
            utgt_q <= '0;
            mis_q  <= 1'b0;
            rv_q   <= 1'b0;
            rpc_q  <= '0;
        end else begin
            upd_q  <= upd_d;
            upc_q  <= upc_d;
            utgt_q <= utgt_d;
            mis_q  <= mis_d;
            rv_q   <= rv_d;
            rpc_q  <= rpc_d;
        end
    end

    assign update         = upd_q;
    assign updatePC       = upc_q;
    assign updateTarget   = utgt_q;
    assign mispredicted   = mis_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;

`ifdef BTB_UPDATE_STATS_EN
    logic [STAT_W-1:0] sbr_q, smis_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sbr_q  <= '0;
            smis_q <= '0;
        end else begin
            if (pop_v && ex_is_branch && sbr_q != '1) sbr_q <= sbr_q + 1'b1;
            if (flush && smis_q != '1) smis_q <= smis_q + 1'b1;
        end
    end

    assign stat_branches    = sbr_q;
    assign stat_mispredicts = smis_q;
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: reference queue model produces
// expected outputs into a scoreboard compared one cycle after each drive.
module tb_btb_update_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_fire, if_hit, if_taken;
    logic [31:0] if_pc, if_target;
    logic        ex_retire, ex_is_branch, ex_taken;
    logic [31:0] ex_target;
    logic        update, mispredicted, redirect_valid, q_full, q_empty;
    logic [31:0] updatePC, updateTarget, redirect_pc;
`ifdef BTB_UPDATE_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    always #5 clk = ~clk;

    btb_update_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_fire        (if_fire),
        .if_pc          (if_pc),
        .if_hit         (if_hit),
        .if_target      (if_target),
        .if_taken       (if_taken),
        .ex_retire      (ex_retire),
        .ex_is_branch   (ex_is_branch),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .update         (update),
        .updatePC       (updatePC),
        .updateTarget   (updateTarget),
        .mispredicted   (mispredicted),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .q_full         (q_full),
        .q_empty        (q_empty)
`ifdef BTB_UPDATE_STATS_EN
       ,.stat_branches    (stat_branches)
       ,.stat_mispredicts (stat_mispredicts)
`endif
    );

    typedef struct {
        bit [31:0] pc;
        bit        hit;
        bit [31:0] tgt;
        bit        tkn;
    } ent_t;

    typedef struct {
        bit        upd;
        bit [31:0] upc;
        bit [31:0] utgt;
        bit        mis;
        bit        rv;
        bit [31:0] rpc;
        bit        full;
        bit        empty;
        bit [31:0] sbr;
        bit [31:0] smis;
    } exp_t;

    ent_t      mq[$];
    exp_t      sb[$];
    exp_t      hold;
    int        n_pass = 0;
    int        n_chk  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Model one clock edge and queue the expected outputs.
    task automatic model(input bit rst, input bit fire, input ent_t ne,
                         input bit ret, input bit isb, input bit etk,
                         input bit [31:0] etgt);
        exp_t e;
        ent_t h;
        bit   pop_ok, mis;
        bit [31:0] pn, an;
        e = hold;
        e.upd = 0;
        e.rv  = 0;
        if (rst) begin
            mq.delete();
            e = '{default: 0};
        end else begin
            pop_ok = ret && mq.size() > 0;
            mis = 0;
            if (pop_ok) begin
                h  = mq.pop_front();
                pn = (h.hit && h.tkn) ? h.tgt : h.pc + 32'd4;
                an = (isb && etk) ? etgt : h.pc + 32'd4;
                mis = (pn != an);
                if (isb) begin
                    e.upd  = 1;
                    e.upc  = h.pc;
                    e.utgt = etgt;
                    e.mis  = mis;
                    if (e.sbr != 32'hFFFF_FFFF) e.sbr++;
                end
                if (mis) begin
                    e.rv  = 1;
                    e.rpc = an;
                    if (e.smis != 32'hFFFF_FFFF) e.smis++;
                    mq.delete();
                end
            end
            if (fire && !mis && mq.size() < 4) mq.push_back(ne);
        end
        e.full  = (mq.size() == 4);
        e.empty = (mq.size() == 0);
        hold = e;
        sb.push_back(e);
    endtask

    task automatic step(input bit rst, input bit fire, input ent_t ne,
                        input bit ret, input bit isb, input bit etk,
                        input bit [31:0] etgt);
        exp_t e;
        rst_n        = !rst;
        if_fire      = fire;
        if_pc        = ne.pc;
        if_hit       = ne.hit;
        if_target    = ne.tgt;
        if_taken     = ne.tkn;
        ex_retire    = ret;
        ex_is_branch = isb;
        ex_taken     = etk;
        ex_target    = etgt;
        model(rst, fire, ne, ret, isb, etk, etgt);
        @(posedge clk);
        #1;
        if_fire   = 0;
        ex_retire = 0;
        e = sb.pop_front();
        check("update", update, e.upd);
        check("updatePC", updatePC, e.upc);
        check("updateTarget", updateTarget, e.utgt);
        check("mispredicted", mispredicted, e.mis);
        check("redirect_valid", redirect_valid, e.rv);
        check("redirect_pc", redirect_pc, e.rpc);
        check("q_full", q_full, e.full);
        check("q_empty", q_empty, e.empty);
`ifdef BTB_UPDATE_STATS_EN
        check("stat_branches", stat_branches, e.sbr);
        check("stat_mispredicts", stat_mispredicts, e.smis);
`endif
    endtask

    ent_t none = '{default: 0};

    task automatic push(input bit [31:0] pc, input bit hit,
                        input bit [31:0] tgt, input bit tkn);
        step(0, 1, '{pc, hit, tgt, tkn}, 0, 0, 0, 0);
    endtask

    task automatic pop(input bit isb, input bit etk, input bit [31:0] etgt);
        step(0, 0, none, 1, isb, etk, etgt);
    endtask

    initial begin
        hold = '{default: 0};
        rst_n = 0; if_fire = 0; if_pc = 0; if_hit = 0; if_target = 0;
        if_taken = 0; ex_retire = 0; ex_is_branch = 0; ex_taken = 0;
        ex_target = 0;
        @(negedge clk);
        step(1, 0, none, 0, 0, 0, 0);
        step(1, 0, none, 0, 0, 0, 0);
        step(0, 0, none, 0, 0, 0, 0);

        // correct taken prediction
        push(32'h100, 1, 32'h200, 1);
        pop(1, 1, 32'h200);
        // BTB miss on a taken branch
        push(32'h40, 0, 32'h0, 0);
        pop(1, 1, 32'h80);
        // alias: taken hit on a non-branch
        push(32'h20, 1, 32'h60, 1);
        pop(0, 0, 32'h0);

        // fill, overflow, push+pop while full, drain across wrap
        for (int i = 0; i < 4; i++) push(32'h1000 + 32'(i * 4), 0, 0, 0);
        push(32'hDEAD0, 0, 0, 0);
        step(0, 1, '{32'h2000, 1, 32'h3000, 1}, 1, 1, 0, 32'h5);
        step(0, 1, '{32'h2010, 0, 0, 0}, 1, 1, 0, 32'h6);
        for (int i = 0; i < 4; i++) pop(1, 0, 32'h7);

        // pop on empty alone, and together with a push
        pop(1, 1, 32'h99);
        step(0, 1, '{32'h500, 0, 0, 0}, 1, 1, 1, 32'h600);
        pop(1, 0, 0);

        // wrap of pc+4 at the top of the address space
        push(32'hFFFF_FFFC, 0, 32'h0, 0);
        pop(1, 0, 32'h1234);
        push(32'hFFFF_FFFC, 1, 32'h0, 0);
        pop(1, 1, 32'h0);

        // push discarded by a flush in the same cycle
        push(32'h700, 1, 32'h900, 1);
        step(0, 1, '{32'h704, 0, 0, 0}, 1, 1, 0, 0);
        pop(1, 0, 0);

        // reset mid-stream with a mispredicting pop pending
        push(32'h800, 1, 32'h880, 1);
        push(32'h804, 0, 0, 0);
        step(1, 1, '{32'h808, 0, 0, 0}, 1, 1, 0, 0);
        step(0, 0, none, 0, 0, 0, 0);

        // 3 branch pops, one mispredicted
        push(32'hA00, 1, 32'hB00, 1);
        pop(1, 1, 32'hB00);
        push(32'hA04, 0, 0, 0);
        pop(1, 0, 0);
        push(32'hA08, 0, 0, 0);
        pop(1, 1, 32'hC00);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            ent_t r;
            r.pc  = {$urandom_range(0, 255), 2'b00} | 32'hFFFF_FC00;
            r.hit = 1'($urandom);
            r.tgt = {$urandom_range(0, 255), 2'b00};
            r.tkn = 1'($urandom);
            step(0, 1'($urandom), r, 1'($urandom), 1'($urandom),
                 1'($urandom), {$urandom_range(0, 255), 2'b00});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
